// File: rtl/tag_hex_streamer.sv
// tag_hex_streamer: turns a captured TAG_BYTES-wide tag ID into a stream of
// uppercase ASCII hex characters (MS nibble first), one character per
// downstream UART handshake (o_Tx_DV out, i_Tx_Done back).
// Optional build macro TAG_STREAM_CRLF_EN appends CR LF to every frame.
module tag_hex_streamer #(
  parameter int TAG_BYTES = 5
) (
  input  logic                   i_Clock,
  input  logic                   i_Rst_n,
  input  logic                   i_Tag_DV,
  input  logic [8*TAG_BYTES-1:0] i_Tag_ID,
  input  logic                   i_Tx_Done,
  output logic                   o_Tx_DV,
  output logic [7:0]             o_Tx_Byte,
  output logic                   o_Busy,
  output logic                   o_Tag_Drop,
  output logic                   o_Frame_Done
);

  localparam int ID_W      = 8*TAG_BYTES;
  localparam int HEX_CHARS = 2*TAG_BYTES;
`ifdef TAG_STREAM_CRLF_EN
  localparam int NUM_CHARS = HEX_CHARS + 2;
`else
  localparam int NUM_CHARS = HEX_CHARS;
`endif
  localparam int IDX_W = $clog2(NUM_CHARS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHARS-1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [ID_W-1:0]  id_q;
  logic             tx_dv_q;
  logic [7:0]       tx_byte_q;
  logic             busy_q;
  logic             drop_q;
  logic             done_q;

  // Captured ID viewed as nibbles; element HEX_CHARS-1 is the MS nibble.
  logic [HEX_CHARS-1:0][3:0] nibs;
  logic [3:0]                nib;
  logic [7:0]                char_d;

  assign nibs = id_q;

  // Select the nibble for the current character index and map it to ASCII.
  always_comb begin
    nib = 4'h0;
    for (int k = 0; k < HEX_CHARS; k++) begin
      if (idx_q == IDX_W'(k)) nib = nibs[HEX_CHARS-1-k];
    end
    if (nib < 4'd10) char_d = 8'h30 + {4'h0, nib};
    else             char_d = 8'h37 + {4'h0, nib};
`ifdef TAG_STREAM_CRLF_EN
    if (idx_q == IDX_W'(HEX_CHARS))        char_d = 8'h0D;
    else if (idx_q == IDX_W'(HEX_CHARS+1)) char_d = 8'h0A;
`endif
  end

  // Frame sequencer: capture, emit one character, wait for its completion.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      id_q      <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      busy_q    <= 1'b0;
      drop_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      tx_dv_q <= 1'b0;
      drop_q  <= 1'b0;
      done_q  <= 1'b0;
      // Any strobe arriving while a frame is in flight (including the cycle
      // of the final i_Tx_Done) is rejected; the ID register is untouched.
      if (i_Tag_DV && (state_q != S_IDLE)) drop_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (i_Tag_DV) begin
            id_q    <= i_Tag_ID;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SEND;
          end
        end
        S_SEND: begin
          tx_dv_q   <= 1'b1;
          tx_byte_q <= char_d;
          state_q   <= S_WAIT;
        end
        S_WAIT: begin
          if (i_Tx_Done) begin
            if (idx_q == LAST_IDX) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              state_q <= S_SEND;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_Tx_DV      = tx_dv_q;
  assign o_Tx_Byte    = tx_byte_q;
  assign o_Busy       = busy_q;
  assign o_Tag_Drop   = drop_q;
  assign o_Frame_Done = done_q;

endmodule

// File: tb/tb_tag_hex_streamer.sv
// Bench for tag_hex_streamer: scoreboard of expected characters, a downstream
// transmitter model (fixed-delay or serial UART), and a serial line decoder.
`timescale 1ns/1ps
module tb_tag_hex_streamer;
  localparam int TB_BYTES = 5;
  localparam int W        = 8*TB_BYTES;
  localparam int HEXN     = 2*TB_BYTES;
`ifdef TAG_STREAM_CRLF_EN
  localparam int NCH = HEXN + 2;
`else
  localparam int NCH = HEXN;
`endif
  localparam int CPB = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tag_dv = 1'b0;
  logic [W-1:0] tag_id = '0;
  logic         man_done = 1'b0;
  logic         resp_done = 1'b0;
  logic         ser = 1'b1;
  logic         tx_done;
  logic         tx_dv, busy, tag_drop, frame_done;
  logic [7:0]   tx_byte;

  int   total = 0, bad = 0, fd_cnt = 0, drop_cnt = 0, rx_ferr = 0;
  bit   resp_en = 1'b0, uart_mode = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] mon_e, resp_byte, rx_byte;
  string hexdig = "0123456789ABCDEF";

  assign tx_done = man_done | resp_done;

  always #5 clk = ~clk;

  tag_hex_streamer #(.TAG_BYTES(TB_BYTES)) dut (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Tag_DV(tag_dv), .i_Tag_ID(tag_id),
    .i_Tx_Done(tx_done), .o_Tx_DV(tx_dv), .o_Tx_Byte(tx_byte), .o_Busy(busy),
    .o_Tag_Drop(tag_drop), .o_Frame_Done(frame_done)
  );

  // Scoreboard monitor: every o_Tx_DV must match the next expected character.
  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (tag_drop) drop_cnt++;
    if (tx_dv) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_dv: got byte %02h, want no o_Tx_DV", tx_byte);
      end else begin
        mon_e = exp_q.pop_front();
        if (tx_byte !== mon_e) begin
          bad++;
          $display("FAIL sb_byte: got %02h, want %02h", tx_byte, mon_e);
        end
      end
    end
  end

  // Downstream transmitter model.
  initial begin
    forever begin
      @(negedge clk);
      if (resp_en && tx_dv) begin
        resp_byte = tx_byte;
        if (uart_mode) begin
          @(posedge clk); #1;
          for (int b = 0; b < 10; b++) begin
            ser = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : resp_byte[b-1];
            repeat (CPB) @(posedge clk);
            #1;
          end
        end else begin
          repeat (3) @(posedge clk);
          #1;
        end
        resp_done = 1'b1;
        @(posedge clk); #1 resp_done = 1'b0;
      end
    end
  end

  // Serial line decoder, mid-bit sampling.
  initial begin
    forever begin
      @(negedge clk);
      if (ser === 1'b0) begin
        repeat (CPB/2) @(negedge clk);
        if (ser === 1'b0) begin
          for (int b = 0; b < 8; b++) begin
            repeat (CPB) @(negedge clk);
            rx_byte[b] = ser;
          end
          repeat (CPB) @(negedge clk);
          if (ser === 1'b1) rx_q.push_back(rx_byte);
          else rx_ferr++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of run, want finish before 500us");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return hexdig[n];
  endfunction

  task automatic push_frame(input logic [W-1:0] id);
    for (int k = 0; k < HEXN; k++) exp_q.push_back(hex_ascii(id[W-1-4*k -: 4]));
`ifdef TAG_STREAM_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endtask

  // Strobe a tag; returns just after the capture edge.
  task automatic start_tag(input logic [W-1:0] id);
    @(posedge clk); #1 tag_id = id; tag_dv = 1'b1;
    @(posedge clk); #1 tag_dv = 1'b0;
  endtask

  task automatic wait_fd(input int budget, input string nm);
    int n = 0;
    @(negedge clk);
    while (frame_done !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    total++;
    if (frame_done !== 1'b1) begin
      bad++;
      $display("FAIL %s_fd_timeout: got no o_Frame_Done, want one within %0d cycles", nm, budget);
    end
  endtask

  // Manually acknowledge one character: wait for o_Tx_DV, answer with i_Tx_Done.
  task automatic ack_char(input string nm);
    int n = 0;
    while (tx_dv !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    total++;
    if (tx_dv !== 1'b1) begin
      bad++;
      $display("FAIL %s_dv_timeout: got no o_Tx_DV, want one within 200 cycles", nm);
    end
    @(posedge clk); #1 man_done = 1'b1;
    @(posedge clk); #1 man_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tag_dv = 1'b1; tag_id = '1; man_done = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (tx_dv !== 1'b0) begin bad++; $display("FAIL rst_tx_dv: got %b want 0", tx_dv); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (tag_drop !== 1'b0) begin bad++; $display("FAIL rst_drop: got %b want 0", tag_drop); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_fd: got %b want 0", frame_done); end
    total++; if (tx_byte !== 8'h00) begin bad++; $display("FAIL rst_byte: got %02h want 00", tx_byte); end
    @(posedge clk); #1 rst_n = 1'b1; tag_dv = 1'b0; man_done = 1'b0;
    @(negedge clk);
    total++; if (tag_drop !== 1'b0) begin bad++; $display("FAIL rst_dv_drop: got %b want 0", tag_drop); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_dv_busy: got %b want 0", busy); end
  endtask

  task automatic test_idle_noise();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 man_done = 1'b1;
      @(posedge clk); #1 man_done = 1'b0;
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
      total++; if (tx_dv !== 1'b0) begin bad++; $display("FAIL idle_tx_dv: got %b want 0", tx_dv); end
    end
  endtask

  task automatic test_basic_frame();
    int fd0;
    logic [7:0] b [12] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44,
                           8'h45, 8'h46, 8'h0D, 8'h0A};
    for (int k = 0; k < NCH; k++) exp_q.push_back(b[k]);
    fd0 = fd_cnt;
    resp_en = 1'b1; uart_mode = 1'b0;
    start_tag(40'h1234ABCDEF);
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", busy); end
    total++; if (tx_dv !== 1'b0) begin bad++; $display("FAIL basic_dv_early: got %b want 0", tx_dv); end
    @(negedge clk);
    total++; if (tx_dv !== 1'b1) begin bad++; $display("FAIL basic_dv_first: got %b want 1", tx_dv); end
    @(negedge clk);
    total++; if (tx_byte !== 8'h31) begin bad++; $display("FAIL basic_byte_hold: got %02h want 31", tx_byte); end
    wait_fd(500, "basic");
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end: got %b want 0", busy); end
    repeat (10) @(negedge clk);
    #1;
    total++; if (fd_cnt !== fd0 + 1) begin bad++; $display("FAIL basic_fd_count: got %0d want %0d", fd_cnt, fd0 + 1); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL basic_left: got %0d want 0", exp_q.size()); end
    resp_en = 1'b0;
  endtask

  task automatic test_drop();
    int d0, n;
    push_frame(40'h1234ABCDEF);
    d0 = drop_cnt;
    resp_en = 1'b1;
    start_tag(40'h1234ABCDEF);
    n = 0;
    while (exp_q.size() > NCH-3 && n < 200) begin @(negedge clk); #1; n++; end
    @(posedge clk); #1 tag_id = '1; tag_dv = 1'b1;
    @(posedge clk); #1 tag_dv = 1'b0;
    @(negedge clk);
    total++; if (tag_drop !== 1'b1) begin bad++; $display("FAIL drop_pulse: got %b want 1", tag_drop); end
    wait_fd(500, "drop");
    repeat (10) @(negedge clk);
    #1;
    total++; if (drop_cnt !== d0 + 1) begin bad++; $display("FAIL drop_count: got %0d want %0d", drop_cnt, d0 + 1); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL drop_left: got %0d want 0", exp_q.size()); end
    resp_en = 1'b0;
  endtask

  task automatic test_boundary();
    int n = 0;
    push_frame(40'h0123456789);
    start_tag(40'h0123456789);
    for (int k = 0; k < NCH-1; k++) ack_char("bnd_a");
    while (tx_dv !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    total++; if (tx_dv !== 1'b1) begin bad++; $display("FAIL bnd_last_dv: got %b want 1", tx_dv); end
    // Final done with a coincident strobe, then a strobe in the frame-done cycle.
    @(posedge clk); #1 man_done = 1'b1; tag_dv = 1'b1; tag_id = 40'hDEADBEEF00;
    push_frame(40'h00C0FFEE11);
    @(posedge clk); #1 man_done = 1'b0; tag_dv = 1'b1; tag_id = 40'h00C0FFEE11;
    @(negedge clk);
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL bnd_fd: got %b want 1", frame_done); end
    total++; if (tag_drop !== 1'b1) begin bad++; $display("FAIL bnd_drop: got %b want 1", tag_drop); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bnd_busy_clr: got %b want 0", busy); end
    @(posedge clk); #1 tag_dv = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL bnd_accept: got %b want 1", busy); end
    total++; if (tag_drop !== 1'b0) begin bad++; $display("FAIL bnd_no_drop: got %b want 0", tag_drop); end
    total++; if (tx_dv !== 1'b0) begin bad++; $display("FAIL bnd_dv_early: got %b want 0", tx_dv); end
    @(negedge clk);
    total++; if (tx_dv !== 1'b1) begin bad++; $display("FAIL bnd_dv_next: got %b want 1", tx_dv); end
    for (int k = 0; k < NCH; k++) ack_char("bnd_b");
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL bnd_fd2: got %b want 1", frame_done); end
    #1;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL bnd_left: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_reset_midframe();
    int fd0, n;
    push_frame(40'h1234ABCDEF);
    resp_en = 1'b1; uart_mode = 1'b0;
    start_tag(40'h1234ABCDEF);
    n = 0;
    while (exp_q.size() > NCH-4 && n < 200) begin @(negedge clk); #1; n++; end
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    exp_q.delete();
    fd0 = fd_cnt;
    @(negedge clk);
    total++; if (tx_dv !== 1'b0) begin bad++; $display("FAIL mrst_tx_dv: got %b want 0", tx_dv); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mrst_busy: got %b want 0", busy); end
    total++; if (tx_byte !== 8'h00) begin bad++; $display("FAIL mrst_byte: got %02h want 00", tx_byte); end
    total++; if (tag_drop !== 1'b0) begin bad++; $display("FAIL mrst_drop: got %b want 0", tag_drop); end
    repeat (30) @(negedge clk);
    #1;
    total++; if (fd_cnt !== fd0) begin bad++; $display("FAIL mrst_no_fd: got %0d want %0d", fd_cnt, fd0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mrst_busy_late: got %b want 0", busy); end
    resp_en = 1'b0;
  endtask

  task automatic test_uart();
    string s;
    logic [7:0] e;
    s = "00000000A5";
    rx_q.delete();
    push_frame(40'h00000000A5);
    resp_en = 1'b1; uart_mode = 1'b1;
    start_tag(40'h00000000A5);
    wait_fd(2000, "uart");
    repeat (5) @(negedge clk);
    #1;
    total++; if (rx_q.size() != NCH) begin bad++; $display("FAIL uart_count: got %0d want %0d", rx_q.size(), NCH); end
    total++; if (rx_ferr != 0) begin bad++; $display("FAIL uart_framing: got %0d want 0", rx_ferr); end
    for (int k = 0; k < NCH && k < rx_q.size(); k++) begin
      e = (k < HEXN) ? s[k] : ((k == HEXN) ? 8'h0D : 8'h0A);
      total++;
      if (rx_q[k] !== e) begin bad++; $display("FAIL uart_char%0d: got %02h want %02h", k, rx_q[k], e); end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL uart_left: got %0d want 0", exp_q.size()); end
    resp_en = 1'b0; uart_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_noise();
    test_basic_frame();
    repeat (5) @(posedge clk);
    test_drop();
    repeat (5) @(posedge clk);
    test_boundary();
    repeat (5) @(posedge clk);
    test_reset_midframe();
    repeat (5) @(posedge clk);
    test_uart();
    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tag_hex_streamer.md
TAG_HEX_STREAMER -- requirements
Module: tag_hex_streamer

Interface
REQ-001 SHALL have parameter TAG_BYTES, default 5, number of tag ID bytes per frame; legal range 1..16.
REQ-002 SHALL have port i_Clock  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port i_Rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port i_Tag_DV  input  1  one-cycle strobe; i_Tag_ID valid.
REQ-005 SHALL have port i_Tag_ID  input  8*TAG_BYTES  tag ID, MS byte first on the wire.
REQ-006 SHALL have port i_Tx_Done  input  1  one-cycle pulse from the downstream UART transmitter on byte completion.
REQ-007 SHALL have port o_Tx_DV  output  1  one-cycle strobe to the downstream UART transmitter; o_Tx_Byte valid.
REQ-008 SHALL have port o_Tx_Byte  output  8  ASCII character to transmit.
REQ-009 SHALL have port o_Busy  output  1  high from tag capture until frame end.
REQ-010 SHALL have port o_Tag_Drop  output  1  one-cycle pulse; tag strobe rejected.
REQ-011 SHALL have port o_Frame_Done  output  1  one-cycle pulse; last character completed.

Function
REQ-012 SHALL implement states IDLE, SEND, WAIT; all outputs registered.
REQ-013 IDLE: on i_Tag_DV, SHALL capture i_Tag_ID, clear character index, set o_Busy, and go to SEND.
REQ-014 SEND: SHALL drive o_Tx_DV high for exactly one cycle with o_Tx_Byte = current character, then go to WAIT; o_Tx_DV SHALL rise the edge after capture.
REQ-015 Character order SHALL be nibbles MS-first: index k selects nibble bits [8*TAG_BYTES-1-4k -: 4] of the captured ID, 2*TAG_BYTES hex characters total.
REQ-016 Nibble-to-ASCII SHALL be uppercase: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46.
REQ-017 WAIT: on i_Tx_Done, if characters remain, SHALL increment index and go to SEND, so the next o_Tx_DV rises the edge after the edge that samples i_Tx_Done.
REQ-018 WAIT: on i_Tx_Done for the last character, SHALL pulse o_Frame_Done, clear o_Busy, and go to IDLE on the same edge.
REQ-019 i_Tag_DV outside IDLE SHALL be ignored, pulse o_Tag_Drop the next cycle, and leave the captured ID unchanged.
REQ-020 i_Tag_DV coincident with the final i_Tx_Done SHALL be dropped; i_Tag_DV in the cycle o_Frame_Done is high SHALL be accepted.
REQ-021 i_Tx_Done in IDLE or SEND SHALL be ignored.
REQ-022 o_Tx_Byte SHALL hold its value from o_Tx_DV until the next o_Tx_DV.
REQ-023 No timeout; WAIT SHALL persist until i_Tx_Done.

Reset
REQ-024 i_Rst_n low at a clock edge SHALL force IDLE, index 0, captured ID 0, and o_Tx_DV, o_Busy, o_Tag_Drop, o_Frame_Done, o_Tx_Byte all 0.
REQ-025 Reset mid-frame SHALL abort without o_Frame_Done; a later stale i_Tx_Done SHALL be ignored per REQ-021.
REQ-026 i_Tag_DV while i_Rst_n is low SHALL be ignored, with no o_Tag_Drop.

Configuration
REQ-027 With macro TAG_STREAM_CRLF_EN defined, each frame SHALL append 0x0D then 0x0A after the hex characters (2*TAG_BYTES+2 characters), and o_Frame_Done SHALL follow the i_Tx_Done of 0x0A.
REQ-028 Without TAG_STREAM_CRLF_EN, the frame SHALL be hex characters only, and o_Frame_Done SHALL follow the last hex character's i_Tx_Done.

Verification
REQ-029 Basic frame: TAG_BYTES=5, ID 0x1234ABCDEF, Done 3 cycles after each DV -> bytes 31 32 33 34 41 42 43 44 45 46 (+0D 0A with macro), one o_Frame_Done.
REQ-030 Drop: second i_Tag_DV (ID 0xFFFFFFFFFF) during the frame of REQ-029 -> o_Tag_Drop pulse, output stream unchanged.
REQ-031 Boundary: i_Tag_DV with the final i_Tx_Done -> dropped; i_Tag_DV in the o_Frame_Done cycle -> new frame, first o_Tx_DV one cycle later.
REQ-032 Reset: i_Rst_n low for 1 cycle after the 4th character's DV, then stray i_Tx_Done -> all outputs 0, no further o_Tx_DV, no o_Frame_Done.
REQ-033 Integration: drive the downstream UART transmitter with CLKS_PER_BIT=4, ID 0x00000000A5 -> serial line decodes "00000000A5" (+CR LF with macro), no lost bytes.
REQ-034 Idle noise: i_Tx_Done pulses in IDLE -> no o_Tx_DV, o_Busy stays 0.
